// File: rtl/ifetch_queue.sv
// Instruction prefetch stage: sequential word fetch, credit-limited in-flight
// requests, show-ahead FIFO to the core, flush/restart on redirect.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] W_LIM = (CW+1)'(DEPTH);

    typedef enum logic {S_FETCH, S_FLUSH} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_data [DEPTH];
    logic [31:0]   r_pc   [DEPTH];

    logic          w_req_fire;
    logic          w_resp_fire;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_sum;
    logic [CW-1:0] w_out_nxt;
    logic [31:0]   w_rpc;
    logic          w_unused_ok;

    assign w_unused_ok = ^redirect_pc[1:0];
    assign w_rpc       = {redirect_pc[31:2], 2'b00};

    // Credit: buffered + in-flight words never exceed FIFO capacity
    assign w_sum = {1'b0, r_count} + {1'b0, r_out};
    assign mem_req_valid = !rst && (r_state == S_FETCH)
                         && (w_sum < W_LIM) && !redirect_valid;
    assign mem_req_addr  = r_fetch_pc;

    assign instr_valid = (r_state == S_FETCH) && (r_count != '0);
    assign instr       = r_data[r_rptr];
    assign instr_pc    = r_pc[r_rptr];

    assign w_req_fire  = mem_req_valid && mem_req_ready;
    assign w_resp_fire = mem_resp_valid;
    assign w_push = w_resp_fire && (r_state == S_FETCH) && !redirect_valid;
    assign w_pop  = instr_valid && instr_ready && !redirect_valid;
    assign w_out_nxt = r_out + CW'(w_req_fire) - CW'(w_resp_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (w_out_nxt != '0) ? S_FLUSH : S_FETCH;
        end else if (r_state == S_FLUSH && w_resp_fire
                     && r_drop == CW'(1)) begin
            w_state_nxt = S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else begin
            r_out <= w_out_nxt;
            if (redirect_valid) begin
                // Every word still in flight now belongs to the old path
                r_fetch_pc <= w_rpc;
                r_resp_pc  <= w_rpc;
                r_drop     <= w_out_nxt;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_req_fire)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (r_state == S_FLUSH && w_resp_fire)
                    r_drop <= r_drop - CW'(1);
                if (w_push) begin
                    r_data[r_wptr] <= mem_resp_data;
                    r_pc[r_wptr]   <= r_resp_pc;
                    r_wptr         <= r_wptr + AW'(1);
                    r_resp_pc      <= r_resp_pc + 32'd4;
                end
                if (w_pop)
                    r_rptr <= r_rptr + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus random traffic against an
// epoch-tagged queue model of memory and the instruction FIFO.
module tb_ifetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] fq[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          ep = 0;
    int          p_rdy, p_ir, lat_lo, lat_hi;
    logic [31:0] exp_req;
    logic        s_rv, s_iv, s_rf, s_rsp;
    logic [31:0] s_addr, s_ipc;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    function automatic bit stale();
        foreach (mq[i]) if (mq[i].ep != ep) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic rd, input logic [31:0] rpc);
        mem_req_ready  = ($urandom_range(99) < p_rdy);
        instr_ready    = ($urandom_range(99) < p_ir);
        redirect_valid = rd;
        redirect_pc    = rpc;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mdata(mq[0].addr);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
        end
    endtask

    task automatic cycle(input logic rd, input logic [31:0] rpc);
        logic  erv, eiv, pop;
        int    lat, due;
        mreq_t e;
        drive(rd, rpc);
        @(negedge clk);
        erv = !rd && !stale() && (fq.size() + mq.size() < DEPTH);
        eiv = (fq.size() != 0);
        s_rv = mem_req_valid; s_addr = mem_req_addr;
        s_iv = instr_valid;   s_ipc  = instr_pc;
        chk("req_valid", 32'(s_rv), 32'(erv));
        chk("req_addr", s_addr, exp_req);
        chk("instr_valid", 32'(s_iv), 32'(eiv));
        if (eiv) begin
            chk("instr_pc", s_ipc, fq[0]);
            chk("instr", instr, mdata(fq[0]));
        end
        s_rf  = s_rv && mem_req_ready;
        s_rsp = mem_resp_valid;
        pop   = eiv && instr_ready && !rd;
        @(posedge clk);
        #1;
        if (pop) void'(fq.pop_front());
        if (s_rsp) begin
            e = mq.pop_front();
            if (!rd && e.ep == ep) fq.push_back(e.addr);
        end
        if (s_rf) begin
            lat = $urandom_range(lat_hi, lat_lo);
            due = (last_due + 1 > cyc + lat) ? last_due + 1 : cyc + lat;
            e.addr = exp_req; e.due = due; e.ep = ep;
            mq.push_back(e);
            last_due = due;
            exp_req  = exp_req + 32'd4;
        end
        if (rd) begin
            fq.delete();
            ep++;
            exp_req = {rpc[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 0; redirect_pc = 0; mem_req_ready = 0;
        mem_resp_valid = 0; mem_resp_data = 0; instr_ready = 0;
        #2;
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_req_addr", mem_req_addr, RPC);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); fq.delete();
        ep++;
        exp_req  = RPC;
        last_due = cyc;
    endtask

    initial begin
        int          n, nrsp;
        bit          seen, seen_iv;
        logic        rd;
        logic [31:0] rpc;
        logic [31:0] wrap_exp [3];
        rst = 0; redirect_valid = 0; redirect_pc = 0; mem_req_ready = 0;
        mem_resp_valid = 0; mem_resp_data = 0; instr_ready = 0;
        p_rdy = 100; p_ir = 100; lat_lo = 1; lat_hi = 1;
        #1;
        do_reset();

        // Back-to-back stream, latency 1
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'h0);
            chk("t1_rv", 32'(s_rv), 32'd1);
            chk("t1_addr", s_addr, 32'(4 * i));
            if (i >= 2) chk("t1_pc", s_ipc, 32'(4 * (i - 2)));
            else        chk("t1_iv", 32'(s_iv), 32'd0);
        end

        // Core stalled: credit stops at DEPTH words
        do_reset();
        p_ir = 0; n = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0);
            if (s_rf) n++;
        end
        chk("t2_nreq", 32'(n), 32'd4);
        chk("t2_stall", 32'(s_rv), 32'd0);
        p_ir = 100; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(1'b0, 32'h0);
            if (s_rf) begin
                chk("t2_resume", s_addr, 32'h10);
                seen = 1;
            end
        end
        chk("t2_resume_seen", 32'(seen), 32'd1);

        // Redirect with three words in flight, latency 5
        do_reset();
        lat_lo = 5; lat_hi = 5;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h203);
        seen = 0; seen_iv = 0; nrsp = 0;
        for (int i = 0; i < 30 && !seen_iv; i++) begin
            cycle(1'b0, 32'h0);
            if (!seen && s_rsp) nrsp++;
            if (!seen && s_rf) begin
                chk("t3_req", s_addr, 32'h200);
                seen = 1;
            end
            if (s_iv) begin
                chk("t3_pc", s_ipc, 32'h200);
                seen_iv = 1;
            end
        end
        chk("t3_dropped", 32'(nrsp), 32'd3);
        chk("t3_seen", 32'(seen_iv), 32'd1);

        // Redirect in the same cycle as a response
        do_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0);
        chk("t4_resp_busy", 32'(s_rsp), 32'd1);
        cycle(1'b1, 32'h400);
        seen_iv = 0;
        for (int i = 0; i < 20 && !seen_iv; i++) begin
            cycle(1'b0, 32'h0);
            if (s_iv) begin
                chk("t4_pc", s_ipc, 32'h400);
                seen_iv = 1;
            end
        end
        chk("t4_seen", 32'(seen_iv), 32'd1);

        // Address wrap at the top of the address space
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        cycle(1'b1, 32'hFFFF_FFF8);
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            cycle(1'b0, 32'h0);
            if (s_rf) begin
                chk("t5_wrap", s_addr, wrap_exp[n]);
                n++;
            end
        end
        chk("t5_count", 32'(n), 32'd3);

        // Random traffic, one asynchronous reset midway
        p_rdy = 70; p_ir = 60; lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) do_reset();
            rd  = ($urandom_range(99) < 3);
            rpc = $urandom_range(1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
            cycle(rd, rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
